// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;
    localparam int          WORD_W           = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - one-entry prefetch buffer holding a fetched word and its address
module ifetch_buf #(
    parameter int WORD_W = cpu_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [WORD_W-1:0] i_data,
    input  logic [WORD_W-1:0] i_pc,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic [WORD_W-1:0] o_pc
);
    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage; IFETCH_PREFETCH_EN adds a one-entry prefetch buffer
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter int          WORD_W   = cpu_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] INSTR,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              branch_en,
    input  logic [WORD_W-1:0] branch_target
);
    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_discard;
    logic              w_ack;
    logic              w_take;
    logic              w_consume;
    logic              w_load_ack;
    logic              w_buf_valid;
    logic [WORD_W-1:0] w_buf_data;
    logic [WORD_W-1:0] w_buf_pc;

    // An ack only counts against a request we are driving; a branch or a pending discard kills its data.
    assign w_ack      = mem_req & mem_ack;
    assign w_take     = w_ack & ~r_discard & ~branch_en;
    assign w_consume  = r_instr_valid & instr_ready;
    assign w_load_ack = w_take & (~r_instr_valid | w_consume);

`ifdef IFETCH_PREFETCH_EN
    ifetch_buf #(.WORD_W(WORD_W)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_flush (branch_en),
        .i_push  (w_take & ~w_load_ack),
        .i_pop   (w_consume & ~w_load_ack & ~branch_en),
        .i_data  (mem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_pc    (w_buf_pc)
    );

    assign mem_req = (r_state == REQ) | ((r_state == HOLD) & ~w_buf_valid);
`else
    assign w_buf_valid = 1'b0;
    assign w_buf_data  = '0;
    assign w_buf_pc    = '0;

    assign mem_req = (r_state == REQ);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = REQ;
            REQ:     if (w_take) w_next_state = HOLD;
            HOLD:    if (w_consume & ~w_take & ~w_buf_valid) w_next_state = REQ;
            default: w_next_state = IDLE;
        endcase
        if (branch_en) begin
            w_next_state = REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_discard     <= 1'b0;
        end else if (branch_en) begin
            // A request still in flight will be acked later with stale data; remember to drop it.
            r_pc          <= branch_target;
            r_discard     <= mem_req & ~mem_ack;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_take) begin
                r_pc <= r_pc + WORD_W'(1);
            end
            if (w_ack) begin
                r_discard <= 1'b0;
            end
            if (w_load_ack) begin
                r_instr       <= mem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end else if (w_consume & w_buf_valid) begin
                r_instr    <= w_buf_data;
                r_instr_pc <= w_buf_pc;
            end else if (w_consume) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign mem_addr    = r_pc;
    assign INSTR       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] INSTR;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
    logic        branch_en;
    logic [15:0] branch_target;

    logic        tb_ack;
    logic [15:0] tb_rdata;
    logic        zero_wait;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    // Zero-wait memory returns a word derived from its address, acked in the request cycle.
    assign mem_ack   = zero_wait ? mem_req : tb_ack;
    assign mem_rdata = zero_wait ? (mem_addr ^ 16'hA5A5) : tb_rdata;

    instr_fetch #(.RESET_PC(16'h0000), .WORD_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .INSTR         (INSTR),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_pc      (instr_pc),
        .branch_en     (branch_en),
        .branch_target (branch_target)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 16'(mem_req), 16'h0001);
    endtask

    task automatic serve(input string tag, input logic [15:0] addr, input logic [15:0] data, input int lat);
        wait_req(tag);
        chk({tag, "_addr"}, mem_addr, addr);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk({tag, "_addr_hold"}, mem_addr, addr);
        end
        tb_ack   = 1'b1;
        tb_rdata = data;
        sb.push_back({addr, data});
        @(negedge clk);
        tb_ack = 1'b0;
    endtask

    task automatic take(input string tag);
        int          n = 0;
        logic [31:0] e;
        while (instr_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 16'(instr_valid), 16'h0001);
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 16'(sb.size()), 16'h0001);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, INSTR, e[15:0]);
            chk({tag, "_pc"}, instr_pc, e[31:16]);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        zero_wait     = 1'b0;
        tb_ack        = 1'b0;
        tb_rdata      = 16'h0000;
        instr_ready   = 1'b0;
        branch_en     = 1'b0;
        branch_target = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_req", 16'(mem_req), 16'h0000);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_instr", INSTR, 16'h0000);
        chk("rst_pc", instr_pc, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'h0000);

`ifndef IFETCH_PREFETCH_EN
        reset = 1'b0;
        serve("t1", 16'h0000, 16'h0810, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t1_stall_instr", INSTR, 16'h0810);
            chk("t1_stall_valid", 16'(instr_valid), 16'h0001);
            chk("t1_stall_noreq", 16'(mem_req), 16'h0000);
            @(negedge clk);
        end
        take("t1");
        serve("t2", 16'h0001, 16'h1234, 2);
        take("t2");

        // branch while a request is outstanding; stale data must be dropped
        wait_req("t3");
        chk("t3_pre_addr", mem_addr, 16'h0002);
        branch_en     = 1'b1;
        branch_target = 16'h0040;
        sb.delete();
        @(negedge clk);
        branch_en = 1'b0;
        chk("t3_br_valid", 16'(instr_valid), 16'h0000);
        chk("t3_br_addr", mem_addr, 16'h0040);
        tb_ack   = 1'b1;
        tb_rdata = 16'hFFFF;
        @(negedge clk);
        tb_ack = 1'b0;
        chk("t3_stale_instr", INSTR, 16'h1234);
        chk("t3_stale_valid", 16'(instr_valid), 16'h0000);
        serve("t3", 16'h0040, 16'h4040, 1);
        take("t3");

        // branch coincident with ack
        wait_req("t4");
        chk("t4_pre_addr", mem_addr, 16'h0041);
        tb_ack        = 1'b1;
        tb_rdata      = 16'h1111;
        branch_en     = 1'b1;
        branch_target = 16'h0100;
        sb.delete();
        @(negedge clk);
        tb_ack    = 1'b0;
        branch_en = 1'b0;
        chk("t4_br_valid", 16'(instr_valid), 16'h0000);
        chk("t4_br_instr", INSTR, 16'h4040);
        chk("t4_br_addr", mem_addr, 16'h0100);
        serve("t4", 16'h0100, 16'h0101, 0);
        take("t4");

        // branch while holding, then PC wrap
        serve("t5", 16'h0101, 16'h2222, 0);
        branch_en     = 1'b1;
        branch_target = 16'hFFFF;
        sb.delete();
        @(negedge clk);
        branch_en = 1'b0;
        chk("t5_br_valid", 16'(instr_valid), 16'h0000);
        chk("t5_br_addr", mem_addr, 16'hFFFF);
        serve("t5b", 16'hFFFF, 16'h5555, 0);
        take("t5b");
        wait_req("t5_wrap");
        chk("t5_wrap_addr", mem_addr, 16'h0000);

        // reset during an outstanding request; ack held through release is ignored
        serve("t6", 16'h0000, 16'h6666, 0);
        take("t6");
        wait_req("t6_pre");
        chk("t6_pre_addr", mem_addr, 16'h0001);
        tb_ack   = 1'b1;
        tb_rdata = 16'hDEAD;
        reset    = 1'b1;
        #1;
        chk("t6_rst_req", 16'(mem_req), 16'h0000);
        chk("t6_rst_addr", mem_addr, 16'h0000);
        chk("t6_rst_instr", INSTR, 16'h0000);
        chk("t6_rst_pc", instr_pc, 16'h0000);
        chk("t6_rst_valid", 16'(instr_valid), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t7_idle_ack_valid", 16'(instr_valid), 16'h0000);
        chk("t7_idle_ack_addr", mem_addr, 16'h0000);
        tb_ack = 1'b0;
        serve("t7", 16'h0000, 16'h7777, 0);
        take("t7");
`else
        begin
            int          n;
            logic [15:0] exp_pc;
            zero_wait   = 1'b1;
            instr_ready = 1'b1;
            reset       = 1'b0;
            n = 0;
            while (instr_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < 8; i++) begin
                exp_pc = 16'(i);
                chk("pf_valid", 16'(instr_valid), 16'h0001);
                chk("pf_pc", instr_pc, exp_pc);
                chk("pf_instr", INSTR, exp_pc ^ 16'hA5A5);
                @(negedge clk);
            end
            instr_ready = 1'b0;
            zero_wait   = 1'b0;
        end
`endif

        chk("sb_empty", 16'(sb.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter WORD_W, default 16, meaning the instruction and address width; only 16 is supported.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port mem_req, output, 1, meaning an instruction-memory read request.
REQ-006 SHALL have port mem_addr, output, 16, meaning the word address of the request.
REQ-007 SHALL have port mem_ack, input, 1, meaning mem_rdata is valid this cycle for the outstanding request.
REQ-008 SHALL have port mem_rdata, input, 16, meaning the returned instruction word.
REQ-009 SHALL have port INSTR, output, 16, meaning the held instruction fed to the ALU decoder.
REQ-010 SHALL have port instr_valid, output, 1, meaning INSTR and instr_pc are valid.
REQ-011 SHALL have port instr_ready, input, 1, meaning the decode/execute stage consumes INSTR this cycle.
REQ-012 SHALL have port instr_pc, output, 16, meaning the address INSTR was fetched from.
REQ-013 SHALL have port branch_en, input, 1, meaning redirect fetch to branch_target.
REQ-014 SHALL have port branch_target, input, 16, meaning the redirect address.

Function
REQ-015 SHALL implement the FSM states IDLE, REQ and HOLD, plus the internal flag discard.
- IDLE -> REQ: one cycle after reset deasserts.
- REQ -> HOLD: on mem_ack with discard clear.
- HOLD -> REQ: on instr_valid & instr_ready.
REQ-016 SHALL assert mem_req exactly while in REQ, with mem_addr equal to the PC, held stable until mem_ack.
REQ-017 SHALL register mem_rdata into INSTR on the accepted mem_ack, and assert instr_valid the next cycle (one-cycle latency).
REQ-018 SHALL hold INSTR, instr_pc and instr_valid stable while instr_valid & ~instr_ready.
REQ-019 SHALL increment the PC by 1 on each accepted mem_ack, wrapping 16'hFFFF to 16'h0000.
REQ-020 SHALL, on branch_en, load the PC with branch_target, clear instr_valid next cycle and enter REQ; branch_en takes priority over every other event.
REQ-021 SHALL, on branch_en while a request is outstanding without ack, set discard, drop the next mem_ack's data, then clear discard and request branch_target.
REQ-022 SHALL, on branch_en coincident with mem_ack, discard that data and issue the next request at branch_target.
REQ-023 SHALL never assert instr_valid for an instruction fetched before the most recent branch_en.

Reset
REQ-024 SHALL, while reset is high, force the state to IDLE, PC to RESET_PC, INSTR to 16'h0000, instr_pc to 16'h0000, and mem_req, instr_valid and discard to 0, asynchronously.
REQ-025 SHALL treat reset during an outstanding request as abandoning it, and ignore any mem_ack received in IDLE.

Configuration
REQ-026 SHALL, with IFETCH_PREFETCH_EN defined, keep requesting in HOLD into a one-entry prefetch buffer, presenting the buffered word the cycle after instr_ready; with zero-wait memory this sustains one instruction per cycle, and branch_en flushes the buffer.
REQ-027 SHALL, without IFETCH_PREFETCH_EN, issue no request while in HOLD; peak throughput is one instruction per two cycles plus the memory wait.

Structure
REQ-028 SHALL place the fetch-state enum, WORD_W and the RESET_PC default in the shared package cpu_pkg.
REQ-029 SHALL implement the prefetch buffer as sub-module ifetch_buf, instantiated only under IFETCH_PREFETCH_EN.

Verification
REQ-030 SHALL verify: reset release with RESET_PC=16'h0000 and mem_ack returning 16'h0810 -> mem_addr 0, then INSTR=16'h0810, instr_valid=1, instr_pc=0.
REQ-031 SHALL verify: instr_ready held low for 5 cycles -> INSTR stable and no mem_req (no macro); on instr_ready=1, the next mem_addr is 1.
REQ-032 SHALL verify: branch_en with target 16'h0040 during an outstanding request, stale ack data 16'hFFFF -> 16'hFFFF never appears on INSTR, and the next mem_addr is 16'h0040.
REQ-033 SHALL verify: PC at 16'hFFFF, ack accepted -> the next mem_addr is 16'h0000.
REQ-034 SHALL verify: reset asserted mid-REQ -> mem_req=0 the same cycle and all outputs at reset values.
REQ-035 SHALL verify: with IFETCH_PREFETCH_EN, zero-wait memory and instr_ready=1 -> instr_valid high on consecutive cycles with instr_pc incrementing by 1.
